mic_fir_scheduler: RTL and testbench

//   Time-multiplexes one shared anti-alias FIR filter (AXI-stream slave/master pair)

---
 rtl/mic_fir_scheduler.sv | 158 +++++++++++++++
 tb/tb_mic_fir_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_fir_scheduler.sv
// Shares one AXI-stream FIR among NUM_CH mics: round-robin issue, tag FIFO, in-order result routing.
// Strobe-to-tvalid 1 cycle; offers are held under tready=0; a full tag FIFO blocks new offers (MIC_SCHED_STATS_EN adds drop counters).
module mic_fir_scheduler #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_CH-1:0]        ch_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
  output logic                     fir_tvalid_out,
  input  logic                     fir_tready_in,
  output logic [DATA_W-1:0]        fir_tdata_out,
  input  logic                     fir_tvalid_in,
  input  logic [DATA_W-1:0]        fir_tdata_in,
  output logic [NUM_CH-1:0]        filt_valid_out,
  output logic [NUM_CH*DATA_W-1:0] filt_data_out,
  output logic [NUM_CH-1:0]        overrun_out,
  output logic                     tag_err_out
`ifdef MIC_SCHED_STATS_EN
  ,
  output logic [NUM_CH*8-1:0]      drop_count_out
`endif
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TP_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TC_W = $clog2(TAG_DEPTH + 1);
  localparam logic [TC_W-1:0] TAG_FULL = TC_W'(TAG_DEPTH);
  localparam logic [TP_W-1:0] TP_LAST  = TP_W'(TAG_DEPTH - 1);

  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] hold    [NUM_CH];
  logic [DATA_W-1:0] filt_q  [NUM_CH];
  logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
  logic [NUM_CH-1:0] pending, pending_nxt, ovr_evt;
  logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt, chan, grant, idx;
  logic [TC_W-1:0]   tag_cnt, tag_cnt_nxt;
  logic [TP_W-1:0]   wr_ptr, rd_ptr;
  logic              grant_vld, refresh, hs, pop, latch;

  assign fir_tvalid_out = (state == OFFER);
  assign hs  = fir_tvalid_out & fir_tready_in;
  assign pop = fir_tvalid_in & (tag_cnt != '0);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data[k] = ch_data_in[k*DATA_W +: DATA_W];
      filt_data_out[k*DATA_W +: DATA_W] = filt_q[k];
      ovr_evt[k] = ch_valid_in[k] & pending[k] & ~(hs & (chan == CH_W'(k)));
    end
  end

  // refresh marks a newer sample for the offered channel, which must stay pending after the handshake
  always_comb begin
    pending_nxt = pending;
    if (hs && !refresh) pending_nxt[chan] = 1'b0;
    pending_nxt = pending_nxt | ch_valid_in;
    rr_ptr_nxt  = hs ? chan : rr_ptr;
    tag_cnt_nxt = tag_cnt + TC_W'(hs) - TC_W'(pop);
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((int'(rr_ptr_nxt) + i) % NUM_CH);
      if (pending_nxt[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld && tag_cnt_nxt < TAG_FULL) begin
          latch     = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          if (grant_vld && tag_cnt_nxt < TAG_FULL) latch = 1'b1;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pending        <= '0;
      rr_ptr         <= CH_W'(NUM_CH - 1);
      chan           <= '0;
      refresh        <= 1'b0;
      fir_tdata_out  <= '0;
      tag_cnt        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      filt_valid_out <= '0;
      overrun_out    <= '0;
      tag_err_out    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        hold[k]   <= '0;
        filt_q[k] <= '0;
      end
      for (int t = 0; t < TAG_DEPTH; t++) tag_mem[t] <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      rr_ptr  <= rr_ptr_nxt;
      tag_cnt <= tag_cnt_nxt;
      overrun_out <= overrun_out | ovr_evt;
      for (int k = 0; k < NUM_CH; k++)
        if (ch_valid_in[k]) hold[k] <= ch_data[k];
      if (latch) begin
        chan          <= grant;
        fir_tdata_out <= ch_valid_in[grant] ? ch_data[grant] : hold[grant];
        refresh       <= 1'b0;
      end else if (fir_tvalid_out && ch_valid_in[chan]) begin
        refresh <= 1'b1;
      end
      if (hs) begin
        tag_mem[wr_ptr] <= chan;
        wr_ptr <= (wr_ptr == TP_LAST) ? '0 : wr_ptr + 1'b1;
      end
      filt_valid_out <= '0;
      if (pop) begin
        rd_ptr <= (rd_ptr == TP_LAST) ? '0 : rd_ptr + 1'b1;
        filt_valid_out[tag_mem[rd_ptr]] <= 1'b1;
        filt_q[tag_mem[rd_ptr]]         <= fir_tdata_in;
      end
      if (fir_tvalid_in && tag_cnt == '0) tag_err_out <= 1'b1;
    end
  end

`ifdef MIC_SCHED_STATS_EN
  logic [7:0] drop_cnt [NUM_CH];

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst_in) drop_cnt[k] <= '0;
      else if (ovr_evt[k] && drop_cnt[k] != 8'hFF) drop_cnt[k] <= drop_cnt[k] + 8'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) drop_count_out[k*8 +: 8] = drop_cnt[k];
  end
`endif
endmodule

// File: tb/tb_mic_fir_scheduler.sv
// Directed bench for mic_fir_scheduler: queue-based reference model checked every cycle, plus literal spot checks.
module tb_mic_fir_scheduler;
  localparam int NUM_CH = 3, DATA_W = 16, TAG_DEPTH = 4;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [NUM_CH-1:0]        ch_valid_in;
  logic [NUM_CH*DATA_W-1:0] ch_data_in;
  logic                     fir_tvalid_out, fir_tready_in;
  logic [DATA_W-1:0]        fir_tdata_out;
  logic                     fir_tvalid_in;
  logic [DATA_W-1:0]        fir_tdata_in;
  logic [NUM_CH-1:0]        filt_valid_out;
  logic [NUM_CH*DATA_W-1:0] filt_data_out;
  logic [NUM_CH-1:0]        overrun_out;
  logic                     tag_err_out;
`ifdef MIC_SCHED_STATS_EN
  logic [NUM_CH*8-1:0]      drop_count_out;
`endif

  always #5 clk_in = ~clk_in;

  mic_fir_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .ch_valid_in(ch_valid_in), .ch_data_in(ch_data_in),
    .fir_tvalid_out(fir_tvalid_out), .fir_tready_in(fir_tready_in), .fir_tdata_out(fir_tdata_out),
    .fir_tvalid_in(fir_tvalid_in), .fir_tdata_in(fir_tdata_in),
    .filt_valid_out(filt_valid_out), .filt_data_out(filt_data_out),
    .overrun_out(overrun_out), .tag_err_out(tag_err_out)
`ifdef MIC_SCHED_STATS_EN
    , .drop_count_out(drop_count_out)
`endif
  );

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the scheduler must present after each clock edge.
  bit                       m_offer, m_fresh, m_terr;
  int                       m_chan, m_last;
  logic [DATA_W-1:0]        m_data;
  bit                       m_pend [NUM_CH];
  logic [DATA_W-1:0]        m_hold [NUM_CH];
  int                       m_tags [$];
  logic [NUM_CH-1:0]        m_fvld, m_ovr;
  logic [NUM_CH*DATA_W-1:0] m_fdata;

  task automatic model_step();
    bit hs, fresh_nxt;
    if (rst_in) begin
      m_offer = 0; m_fresh = 0; m_terr = 0; m_chan = 0; m_last = NUM_CH - 1;
      m_data = '0; m_fvld = '0; m_ovr = '0; m_fdata = '0;
      m_tags.delete();
      for (int k = 0; k < NUM_CH; k++) begin
        m_pend[k] = 0;
        m_hold[k] = '0;
      end
      return;
    end
    hs = m_offer && fir_tready_in;
    m_fvld = '0;
    if (fir_tvalid_in) begin
      if (m_tags.size() > 0) begin
        int k = m_tags.pop_front();
        m_fvld[k] = 1'b1;
        m_fdata[k*DATA_W +: DATA_W] = fir_tdata_in;
      end else begin
        m_terr = 1;
      end
    end
    for (int k = 0; k < NUM_CH; k++)
      if (ch_valid_in[k] && m_pend[k] && !(hs && m_chan == k)) m_ovr[k] = 1'b1;
    fresh_nxt = m_fresh || (m_offer && ch_valid_in[m_chan]);
    if (hs) begin
      m_tags.push_back(m_chan);
      m_last = m_chan;
      if (!fresh_nxt) m_pend[m_chan] = 0;
    end
    for (int k = 0; k < NUM_CH; k++)
      if (ch_valid_in[k]) begin
        m_pend[k] = 1;
        m_hold[k] = ch_data_in[k*DATA_W +: DATA_W];
      end
    m_fresh = fresh_nxt;
    if (!m_offer || hs) begin
      m_offer = 0;
      if (m_tags.size() < TAG_DEPTH)
        for (int i = 1; i <= NUM_CH; i++) begin
          int k = (m_last + i) % NUM_CH;
          if (!m_offer && m_pend[k]) begin
            m_offer = 1; m_chan = k; m_data = m_hold[k]; m_fresh = 0;
          end
        end
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("m_tvalid", fir_tvalid_out, m_offer);
      chk("m_tdata", fir_tdata_out, m_data);
      chk("m_filt_valid", filt_valid_out, m_fvld);
      chk("m_filt_data", filt_data_out, m_fdata);
      chk("m_overrun", overrun_out, m_ovr);
      chk("m_tag_err", tag_err_out, m_terr);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
    ch_valid_in   = '0;
    fir_tvalid_in = 1'b0;
  endtask

  task automatic strobe(input logic [NUM_CH-1:0] m, input logic [DATA_W-1:0] d0, d1, d2);
    ch_valid_in = m;
    ch_data_in  = {d2, d1, d0};
  endtask

  task automatic ret(input logic [DATA_W-1:0] v);
    fir_tvalid_in = 1'b1;
    fir_tdata_in  = v;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; ch_valid_in = '0; ch_data_in = '0;
    fir_tready_in = 1'b0; fir_tvalid_in = 1'b0; fir_tdata_in = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst_tvalid", fir_tvalid_out, 1'b0);
    chk("rst_flags", {overrun_out, tag_err_out, filt_valid_out}, '0);

    // 1: single sample on ch0 and its result
    fir_tready_in = 1'b1;
    strobe(3'b001, 16'h1234, 16'h0, 16'h0); tick();
    chk("t1_tvalid", fir_tvalid_out, 1'b1);
    chk("t1_tdata", fir_tdata_out, 16'h1234);
    tick();
    chk("t1_idle", fir_tvalid_out, 1'b0);
    ret(16'hABCD); tick();
    chk("t1_pulse", filt_valid_out, 3'b001);
    chk("t1_fdata", filt_data_out[15:0], 16'hABCD);
    tick();
    chk("t1_pulse_end", filt_valid_out, 3'b000);

    // 2: round-robin over all three channels
    do_reset();
    fir_tready_in = 1'b1;
    strobe(3'b111, 16'h0001, 16'h0002, 16'h0003); tick();
    chk("t2_offer0", fir_tdata_out, 16'h0001);
    tick(); chk("t2_offer1", fir_tdata_out, 16'h0002);
    tick(); chk("t2_offer2", fir_tdata_out, 16'h0003);
    tick(); chk("t2_idle", fir_tvalid_out, 1'b0);
    ret(16'h000A); tick(); chk("t2_pulse0", filt_valid_out, 3'b001);
    ret(16'h000B); tick(); chk("t2_pulse1", filt_valid_out, 3'b010);
    ret(16'h000C); tick(); chk("t2_pulse2", filt_valid_out, 3'b100);
    chk("t2_fdata", filt_data_out, 48'h000C_000B_000A);

    // 3: backpressure holds the offer; double strobe on ch1 overruns
    do_reset();
    fir_tready_in = 1'b0;
    strobe(3'b001, 16'h00C0, 16'h0, 16'h0); tick();
    chk("t3_hold_a", fir_tdata_out, 16'h00C0);
    strobe(3'b010, 16'h0, 16'h0111, 16'h0); tick();
    chk("t3_hold_b", fir_tdata_out, 16'h00C0);
    strobe(3'b010, 16'h0, 16'h0222, 16'h0); tick();
    chk("t3_overrun", overrun_out, 3'b010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_c", {fir_tvalid_out, fir_tdata_out}, {1'b1, 16'h00C0});
    end
    fir_tready_in = 1'b1;
    tick();
    chk("t3_ch1_late", {fir_tvalid_out, fir_tdata_out}, {1'b1, 16'h0222});
    tick();
    chk("t3_idle", fir_tvalid_out, 1'b0);

    // 4: four tags in flight block the fifth offer until one returns
    do_reset();
    fir_tready_in = 1'b1;
    strobe(3'b111, 16'h00A0, 16'h00A1, 16'h00A2); tick();
    tick();
    strobe(3'b001, 16'h00A3, 16'h0, 16'h0); tick();
    chk("t4_third", fir_tdata_out, 16'h00A2);
    strobe(3'b010, 16'h0, 16'h00A4, 16'h0); tick();
    chk("t4_fourth", fir_tdata_out, 16'h00A3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_blocked", fir_tvalid_out, 1'b0);
    end
    ret(16'h0F00); tick();
    chk("t4_fifth", {fir_tvalid_out, fir_tdata_out}, {1'b1, 16'h00A4});
    chk("t4_ret_pulse", filt_valid_out, 3'b001);
    tick();
    ret(16'h0F01); tick(); chk("t4_drain1", filt_valid_out, 3'b010);
    ret(16'h0F02); tick(); chk("t4_drain2", filt_valid_out, 3'b100);
    ret(16'h0F03); tick(); chk("t4_drain3", filt_valid_out, 3'b001);
    ret(16'h0F04); tick(); chk("t4_drain4", filt_valid_out, 3'b010);

    // 5: stray result with empty tag FIFO
    ret(16'h5555); tick();
    chk("t5_no_pulse", filt_valid_out, 3'b000);
    chk("t5_tag_err", tag_err_out, 1'b1);

    // 6: reset while an offer is stalled
    fir_tready_in = 1'b0;
    strobe(3'b010, 16'h0, 16'h0611, 16'h0); tick();
    chk("t6_offer", fir_tvalid_out, 1'b1);
    tick();
    do_reset();
    chk("t6_rst_tvalid", fir_tvalid_out, 1'b0);
    chk("t6_rst_flags", {overrun_out, tag_err_out, filt_valid_out}, '0);
    chk("t6_rst_tdata", fir_tdata_out, 16'h0000);
    fir_tready_in = 1'b1;
    strobe(3'b100, 16'h0, 16'h0, 16'h0622); tick();
    chk("t6_ch2_first", {fir_tvalid_out, fir_tdata_out}, {1'b1, 16'h0622});
    tick();
    ret(16'h0777); tick();
    chk("t6_pulse", filt_valid_out, 3'b100);
    chk("t6_fdata", filt_data_out, 48'h0777_0000_0000);
    ret(16'h0888); tick();
    chk("t6_stray", {tag_err_out, filt_valid_out}, {1'b1, 3'b000});
    tick();
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
